// File: rtl/key_expansion.sv
// AES-128 key schedule: emits round keys 0..10, one per clock, after a start pulse.
// The S-box is a small combinational lookup used four times for SubWord.

// Combinational AES forward S-box (byte substitution).
module sbox (
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam logic [0:255][7:0] SboxTable = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign data_out = SboxTable[data_in];

endmodule

// Iterative round-key generator; one new round key per clock while running.
module key_expansion (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         round_key_valid,
   output logic [3:0]   round_idx,
   output logic [127:0] round_key,
   output logic         done
);

   localparam logic [3:0] LastRound = 4'd10;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e       state_q, state_d;
   logic [127:0] key_q;
   logic [3:0]   idx_q;
   logic [7:0]   rcon_q;
   logic         done_q;

   logic         accept;
   logic         advance;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  t_word;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] next_key;
   logic [7:0]   next_rcon;

   assign accept  = (state_q == StIdle) && start;
   assign advance = (state_q == StRun) && (idx_q != LastRound);

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // RotWord: first byte of w3 moves to the end.
   assign rot_word = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      sbox u_sbox (
         .data_in  (rot_word[8*i +: 8]),
         .data_out (sub_word[8*i +: 8])
      );
   end

   // Next round key: XOR chain across the four words.
   always_comb begin
      t_word   = sub_word ^ {rcon_q, 24'h0};
      n0       = w0 ^ t_word;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // rcon doubles in GF(2^8); 0x80 wraps to 0x1b.
   assign next_rcon = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: run for exactly eleven cycles per accepted start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StRun;
         StRun:  if (idx_q == LastRound) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Round key, index, rcon and done pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q  <= 128'h0;
         idx_q  <= 4'd0;
         rcon_q <= 8'h01;
         done_q <= 1'b0;
      end else begin
         // done lines up with round 10, which follows round 9 by one edge.
         done_q <= (state_q == StRun) && (idx_q == LastRound - 4'd1);
         if (accept) begin
            key_q  <= key_in;
            idx_q  <= 4'd0;
            rcon_q <= 8'h01;
         end else if (advance) begin
            key_q  <= next_key;
            idx_q  <= idx_q + 4'd1;
            rcon_q <= next_rcon;
         end
      end
   end

   // Outputs decoded from registered state.
   always_comb begin
      busy            = (state_q == StRun);
      round_key_valid = (state_q == StRun);
      round_idx       = idx_q;
      round_key       = key_q;
      done            = done_q;
   end

endmodule
